// File: rtl/ponylink_sdpram.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
// Latency: write visible to the read port on the cycle after the write edge; read is combinational.
// Backpressure: none; the caller must only address valid entries.
module ponylink_sdpram #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Storage write; contents are not reset because pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Fall-through read so the head beat is presented without an extra cycle.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ponylink_pkt_fifo.sv
// Store-and-forward AXI-stream packet FIFO; oversized packets fall back to cut-through.
// Latency: a packet is readable the cycle after its tlast beat is stored (cut-through: cycle after each beat).
// Backpressure: in_tready drops while full; out side holds data stable while out_tready is low.
module ponylink_pkt_fifo #(
    parameter int TDATA_WIDTH = 8,
    parameter int TUSER_WIDTH = 1,
    parameter int DEPTH_LOG2  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TDATA_WIDTH-1:0] in_tdata,
    input  logic [TUSER_WIDTH-1:0] in_tuser,
    input  logic                   in_tvalid,
    input  logic                   in_tlast,
    output logic                   in_tready,
    output logic [TDATA_WIDTH-1:0] out_tdata,
    output logic [TUSER_WIDTH-1:0] out_tuser,
    output logic                   out_tvalid,
    output logic                   out_tlast,
    input  logic                   out_tready,
    output logic [DEPTH_LOG2:0]    fill_level,
    output logic [DEPTH_LOG2:0]    pkt_count,
    output logic                   overflow_cut
);

    localparam int PTR_W  = DEPTH_LOG2 + 1;
    localparam int WORD_W = TUSER_WIDTH + 1 + TDATA_WIDTH;

    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
    localparam logic [PTR_W-1:0] DEPTH_BEATS = {1'b1, {DEPTH_LOG2{1'b0}}};

    // Registered state
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] commit_ptr;
    logic             cut_mode;
    logic [PTR_W-1:0] pkt_cnt_q;
    logic [PTR_W-1:0] fill_q;
    logic             out_vld_q;
    logic             ovf_q;
    // tlast beats of cut-through packets still stored; they were never counted in pkt_count
    logic [PTR_W-1:0] cut_tails_q;

    // Next-state values
    logic [PTR_W-1:0] wr_nxt;
    logic [PTR_W-1:0] rd_nxt;
    logic [PTR_W-1:0] commit_nxt;
    logic             cut_nxt;
    logic [PTR_W-1:0] pkt_cnt_nxt;
    logic [PTR_W-1:0] cut_tails_nxt;

    logic             full;
    logic             wr_en;
    logic             rd_en;
    logic             cut_enter;
    logic             pkt_inc;
    logic             pkt_dec;
    logic             tail_inc;
    logic             tail_dec;

    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    assign full      = (wr_ptr - rd_ptr) == DEPTH_BEATS;
    assign in_tready = !full && !reset;
    assign wr_en     = in_tvalid && in_tready;
    assign rd_en     = out_vld_q && out_tready;

    assign wr_word = {in_tuser, in_tlast, in_tdata};
    assign {out_tuser, out_tlast, out_tdata} = rd_word;

    ponylink_sdpram #(
        .WIDTH      (WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
        .wr_data (wr_word),
        .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
        .rd_data (rd_word)
    );

    // Full with no complete packet stored but a partial one pending: that packet can
    // never complete inside the FIFO, so switch it to cut-through to avoid deadlock.
    assign cut_enter = !cut_mode && full && (pkt_cnt_q == '0) && (commit_ptr != wr_ptr);

    // A stored tlast is either a counted packet end or the end of a cut-through packet.
    // Cut-through tails are always older than any counted packet still stored (cut mode
    // is only entered with pkt_count==0), so the oldest tails are consumed first.
    assign pkt_inc  = wr_en && in_tlast && !cut_mode;
    assign tail_inc = wr_en && in_tlast && cut_mode;
    assign tail_dec = rd_en && out_tlast && (cut_tails_q != '0);
    assign pkt_dec  = rd_en && out_tlast && (cut_tails_q == '0);

    // Pointer, commit and cut-mode next state.
    always_comb begin
        wr_nxt     = wr_ptr;
        rd_nxt     = rd_ptr;
        commit_nxt = commit_ptr;
        cut_nxt    = cut_mode;
        if (wr_en) begin
            wr_nxt = wr_ptr + PTR_ONE;
        end
        if (rd_en) begin
            rd_nxt = rd_ptr + PTR_ONE;
        end
        if (cut_mode) begin
            // Every stored beat is readable; on the tlast write this lands on wr_ptr+1.
            commit_nxt = wr_nxt;
            if (wr_en && in_tlast) begin
                cut_nxt = 1'b0;
            end
        end else if (cut_enter) begin
            // No write can happen while full, so wr_ptr is already the final value.
            cut_nxt    = 1'b1;
            commit_nxt = wr_ptr;
        end else if (wr_en && in_tlast) begin
            commit_nxt = wr_nxt;
        end
    end

    // Packet and cut-tail counters; simultaneous increment and decrement cancel.
    always_comb begin
        pkt_cnt_nxt   = pkt_cnt_q;
        cut_tails_nxt = cut_tails_q;
        case ({pkt_inc, pkt_dec})
            2'b10:   pkt_cnt_nxt = pkt_cnt_q + PTR_ONE;
            2'b01:   pkt_cnt_nxt = pkt_cnt_q - PTR_ONE;
            default: pkt_cnt_nxt = pkt_cnt_q;
        endcase
        case ({tail_inc, tail_dec})
            2'b10:   cut_tails_nxt = cut_tails_q + PTR_ONE;
            2'b01:   cut_tails_nxt = cut_tails_q - PTR_ONE;
            default: cut_tails_nxt = cut_tails_q;
        endcase
    end

    // State register; reset discards everything including partial packets.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            commit_ptr  <= '0;
            cut_mode    <= 1'b0;
            pkt_cnt_q   <= '0;
            fill_q      <= '0;
            out_vld_q   <= 1'b0;
            ovf_q       <= 1'b0;
            cut_tails_q <= '0;
        end else begin
            wr_ptr      <= wr_nxt;
            rd_ptr      <= rd_nxt;
            commit_ptr  <= commit_nxt;
            cut_mode    <= cut_nxt;
            pkt_cnt_q   <= pkt_cnt_nxt;
            fill_q      <= wr_nxt - rd_nxt;
            out_vld_q   <= (rd_nxt != commit_nxt);
            ovf_q       <= cut_enter;
            cut_tails_q <= cut_tails_nxt;
        end
    end

    assign out_tvalid   = out_vld_q;
    assign fill_level   = fill_q;
    assign pkt_count    = pkt_cnt_q;
    assign overflow_cut = ovf_q;

endmodule
